// File: rtl/energy_accumulator.sv
// Windowed energy accumulator: measures master/worker toggle deltas and core
// activity over fixed-length windows and holds each result until acknowledged.
module energy_accumulator #(
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned NUM_CORES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] master_toggles,
    input  logic [31:0] worker_toggles,
    input  logic [2:0]  active_count,
    input  logic        report_ack,
    output logic        report_valid,
    output logic [31:0] master_delta,
    output logic [31:0] worker_delta,
    output logic [35:0] baseline,
    output logic [35:0] optimized,
    output logic [35:0] saved,
    output logic [23:0] active_sum,
    output logic [15:0] window_id,
    output logic        overrun
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [15:0] LAST_CYCLE = 16'(WINDOW - 1);
    localparam logic [35:0] CORES      = 36'(NUM_CORES);
    localparam logic [35:0] WORKERS    = 36'(NUM_CORES - 1);

    state_t      state;
    logic [15:0] cycle_count;
    logic [23:0] running_sum;
    logic [31:0] snap_master;
    logic [31:0] snap_worker;

    logic        window_end;
    logic [31:0] master_next;
    logic [31:0] worker_next;
    logic [23:0] sum_next;
    logic [35:0] baseline_next;
    logic [35:0] optimized_next;

    always_comb begin
        window_end     = (state == MEASURE) && (cycle_count == LAST_CYCLE);
        master_next    = master_toggles - snap_master;
        worker_next    = worker_toggles - snap_worker;
        sum_next       = running_sum + {21'b0, active_count};
        baseline_next  = {4'b0, master_next} * CORES;
        optimized_next = {4'b0, master_next} + ({4'b0, worker_next} * WORKERS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cycle_count  <= '0;
            running_sum  <= '0;
            snap_master  <= '0;
            snap_worker  <= '0;
            report_valid <= 1'b0;
            master_delta <= '0;
            worker_delta <= '0;
            baseline     <= '0;
            optimized    <= '0;
            saved        <= '0;
            active_sum   <= '0;
            window_id    <= '0;
            overrun      <= 1'b0;
        end else begin
            // An ack clears the held report; a window end on the same edge reloads it below.
            if (report_ack)
                report_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        snap_master <= master_toggles;
                        snap_worker <= worker_toggles;
                        cycle_count <= '0;
                        running_sum <= '0;
                        state       <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (window_end) begin
                        master_delta <= master_next;
                        worker_delta <= worker_next;
                        baseline     <= baseline_next;
                        optimized    <= optimized_next;
                        saved        <= baseline_next - optimized_next;
                        active_sum   <= sum_next;
                        report_valid <= 1'b1;
                        window_id    <= window_id + 16'd1;
                        if (report_valid && !report_ack)
                            overrun <= 1'b1;
                        snap_master  <= master_toggles;
                        snap_worker  <= worker_toggles;
                        cycle_count  <= '0;
                        running_sum  <= '0;
                        if (!enable)
                            state <= IDLE;
                    end else if (!enable) begin
                        state <= IDLE;
                    end else begin
                        running_sum <= sum_next;
                        cycle_count <= cycle_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
